// File: rtl/seq_shifter.sv
// seq_shifter: multi-cycle barrel-free shifter, one bit per cycle.
//   clk, rst        : clock, synchronous active-high reset
//   in_valid/ready  : request handshake; a (operand), b (amount), op (select)
//   out_valid/ready : result handshake; res, flags {N,Z,C,V}, err (bad op)
module seq_shifter #(
    parameter logic [3:0] OP_SLL = 4'd5,
    parameter logic [3:0] OP_SRL = 4'd6,
    parameter logic [3:0] OP_SRA = 4'd7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  op,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] res,
    output logic [3:0]  flags,
    output logic        err
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 6;
    localparam int unsigned OP_W   = 4;
    localparam int unsigned FLAG_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   work_q, work_d;
    logic [CNT_W-1:0]    n_q, n_d;
    logic [OP_W-1:0]     op_q, op_d;
    logic                sign_q, sign_d;
    logic                bad_q, bad_d;

    logic                in_ready_q, in_ready_d;
    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   res_q, res_d;
    logic [FLAG_W-1:0]   flags_q, flags_d;
    logic                err_q, err_d;

    logic [CNT_W-1:0]    n_load;
    logic                op_ok;

    // Saturate the full-width shift amount to 32.
    assign n_load = (b >= DATA_W'(32)) ? CNT_W'(32) : b[CNT_W-1:0];
    assign op_ok  = (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);

    // Next-state, datapath and output computation.
    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        n_d     = n_q;
        op_d    = op_q;
        sign_d  = sign_q;
        bad_d   = bad_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    work_d  = a;
                    op_d    = op;
                    sign_d  = a[DATA_W-1];
                    n_d     = n_load;
                    bad_d   = !op_ok;
                    state_d = (!op_ok || (n_load == '0)) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (op_q == OP_SLL) begin
                    work_d = {work_q[DATA_W-2:0], 1'b0};
                end else if (op_q == OP_SRL) begin
                    work_d = {1'b0, work_q[DATA_W-1:1]};
                end else begin
                    work_d = {sign_q, work_q[DATA_W-1:1]};
                end
                n_d = n_q - CNT_W'(1);
                if (n_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered from the next state so they line up with it.
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        res_d       = '0;
        flags_d     = '0;
        err_d       = 1'b0;
        if (state_d == DONE) begin
            res_d   = work_d;
            err_d   = bad_d;
            flags_d = {work_d[DATA_W-1], (work_d == '0), 2'b00};
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            work_q      <= '0;
            n_q         <= '0;
            op_q        <= '0;
            sign_q      <= 1'b0;
            bad_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            res_q       <= '0;
            flags_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            work_q      <= work_d;
            n_q         <= n_d;
            op_q        <= op_d;
            sign_q      <= sign_d;
            bad_q       <= bad_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            res_q       <= res_d;
            flags_q     <= flags_d;
            err_q       <= err_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign res       = res_q;
    assign flags     = flags_q;
    assign err       = err_q;

endmodule

// File: tb/tb_seq_shifter.sv
// tb_seq_shifter: directed vectors for seq_shifter with hand-computed results.
module tb_seq_shifter;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] res;
    logic [3:0]  flags;
    logic        err;

    int n_checks = 0;
    int n_pass   = 0;

    seq_shifter dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res       (res),
        .flags     (flags),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Wait (bounded) until the unit is idle; caller is at a negedge.
    task automatic wait_idle();
        int t = 0;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("idle_wait", 32'(in_ready), 32'd1);
    endtask

    // Issue one request, scramble inputs while busy, then check result and latency.
    task automatic run_op(input string tag, input logic [31:0] va, input logic [31:0] vb,
                          input logic [3:0] vop, input logic [31:0] exp_res,
                          input logic [3:0] exp_flags, input logic exp_err, input int exp_lat);
        int lat;
        wait_idle();
        in_valid  = 1'b1;
        a         = va;
        b         = vb;
        op        = vop;
        out_ready = 1'b0;
        @(negedge clk);
        lat = 1;
        while (!out_valid && lat < 40) begin
            a  = $urandom;
            b  = $urandom;
            op = 4'($urandom);
            @(negedge clk);
            lat++;
        end
        in_valid = 1'b0;
        check({tag, "_lat"},   32'(lat),       32'(exp_lat));
        check({tag, "_res"},   res,            exp_res);
        check({tag, "_flags"}, 32'(flags),     32'(exp_flags));
        check({tag, "_err"},   32'(err),       32'(exp_err));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_retire"}, {30'd0, out_valid, in_ready}, 32'b01);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        op        = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_res",       res,            32'd0);
        check("rst_flags",     32'(flags),     32'd0);
        check("rst_err",       32'(err),       32'd0);

        run_op("sll4",    32'h0000000f, 32'd4,        4'd5, 32'h000000f0, 4'b0000, 1'b0, 5);
        run_op("sll31",   32'h0000000f, 32'd31,       4'd5, 32'h80000000, 4'b1000, 1'b0, 32);
        run_op("sllmax",  32'h0000000f, 32'hffffffff, 4'd5, 32'h00000000, 4'b0100, 1'b0, 33);
        run_op("srl3",    32'd15,       32'd3,        4'd6, 32'd1,        4'b0000, 1'b0, 4);
        run_op("srl1",    32'd1,        32'd1,        4'd6, 32'd0,        4'b0100, 1'b0, 2);
        run_op("srl32",   32'hffffffff, 32'd32,       4'd6, 32'd0,        4'b0100, 1'b0, 33);
        run_op("sra4",    32'h80000000, 32'd4,        4'd7, 32'hf8000000, 4'b1000, 1'b0, 5);
        run_op("sra40",   32'h80000000, 32'd40,       4'd7, 32'hffffffff, 4'b1000, 1'b0, 33);
        run_op("sra_pos", 32'h40000000, 32'd2,        4'd7, 32'h10000000, 4'b0000, 1'b0, 3);
        run_op("zero",    32'h12345678, 32'd0,        4'd5, 32'h12345678, 4'b0000, 1'b0, 1);
        run_op("badop",   32'h87654321, 32'd5,        4'd2, 32'h87654321, 4'b1000, 1'b1, 1);

        // Back-pressure: result must hold while out_ready stays low.
        wait_idle();
        in_valid = 1'b1;
        a  = 32'h00000003;
        b  = 32'd2;
        op = 4'd5;
        @(negedge clk);
        in_valid = 1'b0;
        begin
            int t = 0;
            while (!out_valid && t < 40) begin
                @(negedge clk);
                t++;
            end
        end
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_ready", 32'(in_ready),  32'd0);
            check("bp_res",   res,            32'h0000000c);
            check("bp_flags", 32'(flags),     32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_retire", {30'd0, out_valid, in_ready}, 32'b01);

        // Reset mid-shift abandons the operation.
        in_valid = 1'b1;
        a  = 32'hffff0000;
        b  = 32'd20;
        op = 4'd6;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_in_ready",  32'(in_ready),  32'd1);
        check("rst_mid_out_valid", 32'(out_valid), 32'd0);
        check("rst_mid_res",       res,            32'd0);
        begin
            int seen = 0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (out_valid) seen++;
            end
            check("rst_mid_stale", 32'(seen), 32'd0);
        end

        // Reset wins over a same-edge accept.
        in_valid = 1'b1;
        a  = 32'h1;
        b  = 32'd8;
        op = 4'd5;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("rst_prio_in_ready", 32'(in_ready), 32'd1);
        run_op("post_rst", 32'h00000001, 32'd8, 4'd5, 32'h00000100, 4'b0000, 1'b0, 9);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/seq_shifter.md
SEQ_SHIFTER -- requirements
Module: seq_shifter

Interface
REQ-001 SHALL have parameter OP_SLL, default 4'd5, meaning the op code for logical shift left (matches ALU encoding).
REQ-002 SHALL have parameter OP_SRL, default 4'd6, meaning the op code for logical shift right.
REQ-003 SHALL have parameter OP_SRA, default 4'd7, meaning the op code for arithmetic shift right.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port in_valid, input, 1 bit: the request is valid.
REQ-007 SHALL have port in_ready, output, 1 bit: the unit can accept a request.
REQ-008 SHALL have port a, input, 32 bits: the operand to shift.
REQ-009 SHALL have port b, input, 32 bits: the shift amount, unsigned, full width.
REQ-010 SHALL have port op, input, 4 bits: the operation select.
REQ-011 SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-012 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-013 SHALL have port res, output, 32 bits: the shift result.
REQ-014 SHALL have port flags, output, 4 bits: {N,Z,C,V}, in the same layout as the ALU flags.
REQ-015 SHALL have port err, output, 1 bit: the op code is unsupported.

Function
REQ-016 SHALL implement a state machine with states IDLE, SHIFT and DONE; in_ready=1 only in IDLE, and out_valid=1 only in DONE.
REQ-017 SHALL accept a request on a rising edge where in_valid=1 and in_ready=1; it latches a and op, and loads a count register n=min(b,32) (any b>=32, including 32'hffffffff, gives n=32).
REQ-018 SHALL, on accept, go to DONE if n=0 or op is unsupported, and otherwise go to SHIFT.
REQ-019 SHALL, in SHIFT, shift the working register by exactly 1 bit per cycle and decrement n; the shift is SLL (zero fill at bit 0), SRL (zero fill at bit 31) or SRA (fill with the bit-31 value latched at accept).
REQ-020 SHALL go from SHIFT to DONE on the edge that performs the last shift (n goes 1->0).
REQ-021 SHALL assert out_valid starting n+1 cycles after the accept edge, with latency 1 for n=0 and latency 33 for n=32.
REQ-022 SHALL give, for n=32, res=0 for SLL and SRL, and res=32{a[31]} for SRA.
REQ-023 SHALL, for an unsupported op, set res=a unchanged and err=1, with latency 1; for supported ops err=0.
REQ-024 SHALL compute flags from the final res while in DONE: N=res[31], Z=(res==0), C=0, V=0.
REQ-025 SHALL hold res, flags and err stable while out_valid=1 and out_ready=0, for any number of cycles.
REQ-026 SHALL go from DONE to IDLE on an edge with out_valid=1 and out_ready=1; in_ready rises in the following cycle, so there is no same-cycle result-retire and new accept.
REQ-027 SHALL ignore in_valid, a, b and op while in SHIFT or DONE; changing these inputs mid-operation SHALL NOT affect the result.
REQ-028 SHALL ignore out_ready outside DONE.
REQ-029 SHALL drive res, flags and err to 0 in IDLE and SHIFT; they are valid only with out_valid.

Reset
REQ-030 SHALL, on an edge with rst=1, enter IDLE, clear n and the working register, and drive in_ready=1 in the next cycle and out_valid=0, res=0, flags=0, err=0.
REQ-031 SHALL, on rst=1 mid-SHIFT or in DONE, abandon the operation and produce no out_valid for it.
REQ-032 SHALL give rst priority over accept and retire on the same edge.

Verification
REQ-033 SHALL cover SLL: a=32'h0000000f, b=4, op=5 -> out_valid 5 cycles after accept, res=32'h000000f0, flags=4'b0000.
REQ-034 SHALL cover SLL: a=32'h0000000f, b=31 -> res=32'h80000000, flags=4'b1000, latency 32; and b=32'hffffffff -> res=0, flags=4'b0100, latency 33.
REQ-035 SHALL cover SRL: a=15, b=3, op=6 -> res=1, flags=4'b0000; and a=1, b=1 -> res=0, flags=4'b0100.
REQ-036 SHALL cover SRA: a=32'h80000000, b=4, op=7 -> res=32'hf8000000, flags=4'b1000; and b=40 -> res=32'hffffffff.
REQ-037 SHALL cover the zero-shift and bad-op cases: b=0 -> latency 1, res=a; op=2 -> err=1, res=a, latency 1.
REQ-038 SHALL cover back-pressure and reset: hold out_ready=0 for 5 cycles -> res/flags stable and in_ready=0; assert rst mid-SHIFT -> next cycle in_ready=1, out_valid=0 and no stale result.
